hazard_ctrl: RTL and testbench

Pipeline scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It takes the decoded ID-stage operand-use and writeback information from the instruction decoder and tracks in-flight destination registers in its own EX/MEM/WB shadow pipeline. From that state it produces PC/IF-ID stall, IF-ID and ID-EX flush, and operand forwarding selects. It also keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard scheduler for the 5-stage RV32I pipeline
//               (IF/ID/EX/MEM/WB).
//               The ID stage's decoded register usage is compared against
//               destination registers still in flight. Those are held in a
//               local EX/MEM/WB shadow pipeline. The block drives the
//               PC/IF-ID stalls, the IF-ID and ID-EX flushes, and the
//               operand forwarding selects. It also keeps a saturating
//               count of stalled cycles.
//
// Build macro : FORWARD_EN
//               defined   - EX/MEM/WB forwarding is enabled. Only a load
//                           followed directly by a use of its result stalls
//                           (1 cycle).
//               undefined - no forwarding, so fwd_a/fwd_b are always 00.
//                           Any use of a register still in flight stalls
//                           until the producer has drained.
//
// Parameters  : CNT_W     - width of the stall-cycle counter
//               RF_BYPASS - 1: the register file writes before it reads, so
//                           a WB-stage producer is never a hazard.
//                           0: a WB-stage producer is a hazard.
//
// Ports       : clk, rst               clock, synchronous active-high reset
//               id_rs1/id_rs2/id_rd    ID-stage register specifiers
//               id_re1/id_re2          ID instruction reads rs1/rs2
//               id_rf_we               ID instruction writes rd
//               id_wd_sel              ID writeback source (2'b01 = load)
//               ex_redirect            EX resolved a taken branch/jump
//               stall_pc/stall_ifid    hold PC and IF/ID
//               flush_ifid/flush_idex  load a bubble into IF/ID and ID/EX
//               fwd_a/fwd_b            operand source: 00 RF, 01 EX,
//                                      10 MEM, 11 WB
//               stall_cycles           saturating count of stalled cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic             id_rf_we,
    input  logic [1:0]       id_wd_sel,
    input  logic             ex_redirect,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_WD_LOAD = 2'b01;

    // Shadow pipeline of in-flight destinations
    logic [4:0]       r_ex_rd;
    logic             r_ex_we;
    logic             r_ex_ld;
    logic [4:0]       r_mem_rd;
    logic             r_mem_we;
    logic             r_mem_ld;
    logic [4:0]       r_wb_rd;
    logic             r_wb_we;
    logic [CNT_W-1:0] r_stall_cycles;

    logic       w_use1;
    logic       w_use2;
    logic       w_ex_hit1;
    logic       w_ex_hit2;
    logic       w_mem_hit1;
    logic       w_mem_hit2;
    logic       w_wb_hit1;
    logic       w_wb_hit2;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_unused;

    assign w_use1 = id_re1 & (id_rs1 != 5'd0);
    assign w_use2 = id_re2 & (id_rs2 != 5'd0);

    // x0 is hard-wired to zero, so it never hazards or forwards
    assign w_ex_hit1  = r_ex_we  & (r_ex_rd  == id_rs1) & (r_ex_rd  != 5'd0);
    assign w_ex_hit2  = r_ex_we  & (r_ex_rd  == id_rs2) & (r_ex_rd  != 5'd0);
    assign w_mem_hit1 = r_mem_we & (r_mem_rd == id_rs1) & (r_mem_rd != 5'd0);
    assign w_mem_hit2 = r_mem_we & (r_mem_rd == id_rs2) & (r_mem_rd != 5'd0);
    assign w_wb_hit1  = r_wb_we  & (r_wb_rd  == id_rs1) & (r_wb_rd  != 5'd0);
    assign w_wb_hit2  = r_wb_we  & (r_wb_rd  == id_rs2) & (r_wb_rd  != 5'd0);

`ifdef FORWARD_EN
    localparam logic [1:0] c_FWD_EX  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;
    localparam logic [1:0] c_FWD_WB  = 2'b11;

    // The youngest producer wins. When the EX producer is a load, its data
    // does not exist yet. That case stalls instead, so the select is parked
    // at RF.
    function automatic logic [1:0] fwd_sel(input logic use_op, input logic ex_hit,
                                           input logic ex_ld, input logic mem_hit,
                                           input logic wb_hit);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (use_op) begin
            if (ex_hit) begin
                sel = ex_ld ? c_FWD_RF : c_FWD_EX;
            end else if (mem_hit) begin
                sel = c_FWD_MEM;
            end else if (wb_hit) begin
                sel = c_FWD_WB;
            end
        end
        return sel;
    endfunction

    assign w_stall = ((w_use1 & w_ex_hit1) | (w_use2 & w_ex_hit2)) & r_ex_ld & ~ex_redirect;
    assign w_fwd_a = fwd_sel(w_use1, w_ex_hit1, r_ex_ld, w_mem_hit1, w_wb_hit1);
    assign w_fwd_b = fwd_sel(w_use2, w_ex_hit2, r_ex_ld, w_mem_hit2, w_wb_hit2);
    // A load in MEM is forwarded like any other result, so its load flag is
    // not needed here.
    assign w_unused = ^{r_mem_ld, (RF_BYPASS != 0)};
`else
    // Without forwarding, any reader waits until its producer has left every
    // stage that the register file cannot yet see.
    localparam logic c_WB_HAZ = (RF_BYPASS == 0);

    assign w_stall = ((w_use1 & (w_ex_hit1 | w_mem_hit1 | (c_WB_HAZ & w_wb_hit1))) |
                      (w_use2 & (w_ex_hit2 | w_mem_hit2 | (c_WB_HAZ & w_wb_hit2))))
                     & ~ex_redirect;
    assign w_fwd_a = c_FWD_RF;
    assign w_fwd_b = c_FWD_RF;
    assign w_unused = ^{r_ex_ld, r_mem_ld};
`endif

    // While reset is held, every control output is forced low
    assign stall_pc     = w_stall & ~rst;
    assign stall_ifid   = w_stall & ~rst;
    assign flush_ifid   = ex_redirect & ~rst;
    assign flush_idex   = ex_redirect & ~rst;
    assign fwd_a        = rst ? c_FWD_RF : w_fwd_a;
    assign fwd_b        = rst ? c_FWD_RF : w_fwd_b;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd        <= 5'd0;
            r_ex_we        <= 1'b0;
            r_ex_ld        <= 1'b0;
            r_mem_rd       <= 5'd0;
            r_mem_we       <= 1'b0;
            r_mem_ld       <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_we        <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            // A flushed or stalled ID instruction must not enter EX, so EX
            // gets a bubble instead. A redirect already suppresses the stall.
            if (ex_redirect | w_stall) begin
                r_ex_rd <= 5'd0;
                r_ex_we <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_rd <= id_rd;
                r_ex_we <= id_rf_we;
                r_ex_ld <= (id_wd_sel == c_WD_LOAD);
            end
            // The back end never stalls
            r_mem_rd <= r_ex_rd;
            r_mem_we <= r_ex_we;
            r_mem_ld <= r_ex_ld;
            r_wb_rd  <= r_mem_rd;
            r_wb_we  <= r_mem_we;

            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
module tb_hazard_ctrl;

    // In-flight producer as seen by the reference model.
    // The index is the distance from ID: 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } slot_t;
    typedef slot_t [2:0] pipe_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic [4:0] id_rd = '0;
    logic       id_re1 = 1'b0;
    logic       id_re2 = 1'b0;
    logic       id_rf_we = 1'b0;
    logic [1:0] id_wd_sel = '0;
    logic       ex_redirect = 1'b0;

    // u1: RF_BYPASS=1, 32-bit counter.  u0: RF_BYPASS=0, 3-bit counter.
    logic        spc1, sif1, fif1, fex1;
    logic [1:0]  fa1, fb1;
    logic [31:0] cnt1;
    logic        spc0, sif0, fif0, fex0;
    logic [1:0]  fa0, fb0;
    logic [2:0]  cnt0;

    hazard_ctrl #(.CNT_W(32), .RF_BYPASS(1)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_re1(id_re1), .id_re2(id_re2), .id_rf_we(id_rf_we), .id_wd_sel(id_wd_sel),
        .ex_redirect(ex_redirect), .stall_pc(spc1), .stall_ifid(sif1),
        .flush_ifid(fif1), .flush_idex(fex1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_cycles(cnt1)
    );

    hazard_ctrl #(.CNT_W(3), .RF_BYPASS(0)) u_dut0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_re1(id_re1), .id_re2(id_re2), .id_rf_we(id_rf_we), .id_wd_sel(id_wd_sel),
        .ex_redirect(ex_redirect), .stall_pc(spc0), .stall_ifid(sif0),
        .flush_ifid(fif0), .flush_idex(fex0), .fwd_a(fa0), .fwd_b(fb0),
        .stall_cycles(cnt0)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    pipe_t m1_p = '0;
    pipe_t m0_p = '0;
    longint m1_cnt = 0;
    longint m0_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Distance to the youngest in-flight writer of rs, or -1 if none
    function automatic void nearest(input pipe_t p, input logic [4:0] rs, input logic re,
                                    output int d, output logic ld);
        d  = -1;
        ld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (re && rs != 5'd0 && p[k].we && p[k].rd == rs) begin
                d  = k;
                ld = p[k].ld;
            end
        end
    endfunction

`ifdef FORWARD_EN
    function automatic logic [1:0] src_of(input int d, input logic ld);
        if (d < 0)  return 2'd0;
        if (d == 0) return ld ? 2'd0 : 2'd1;
        return 2'(d + 1);
    endfunction
`endif

    function automatic exp_t predict(input pipe_t p, input bit bypass);
        exp_t e;
        int   d1, d2;
        logic l1, l2;
        e = '0;
        nearest(p, id_rs1, id_re1, d1, l1);
        nearest(p, id_rs2, id_re2, d2, l2);
        if (!rst) begin
            e.flush = ex_redirect;
`ifdef FORWARD_EN
            e.stall = ((d1 == 0 && l1) || (d2 == 0 && l2)) && !ex_redirect;
            e.fa    = src_of(d1, l1);
            e.fb    = src_of(d2, l2);
`else
            // A producer is visible through the RF once past this distance
            e.stall = ((d1 >= 0 && d1 < (bypass ? 2 : 3)) ||
                       (d2 >= 0 && d2 < (bypass ? 2 : 3))) && !ex_redirect;
`endif
        end
        return e;
    endfunction

    // Reference model state advance
    always @(posedge clk) begin
        exp_t  e1, e0;
        slot_t n1, n0;
        e1 = predict(m1_p, 1'b1);
        e0 = predict(m0_p, 1'b0);
        if (rst) begin
            m1_p = '0; m0_p = '0; m1_cnt = 0; m0_cnt = 0;
        end else begin
            if (e1.stall && m1_cnt < 64'hFFFF_FFFF) m1_cnt++;
            if (e0.stall && m0_cnt < 7) m0_cnt++;
            n1 = '0; n0 = '0;
            if (!(ex_redirect || e1.stall)) n1 = {id_rd, id_rf_we, id_wd_sel == 2'b01};
            if (!(ex_redirect || e0.stall)) n0 = {id_rd, id_rf_we, id_wd_sel == 2'b01};
            m1_p = {m1_p[1], m1_p[0], n1};
            m0_p = {m0_p[1], m0_p[0], n0};
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        exp_t e1, e0;
        if (chk_en) begin
            e1 = predict(m1_p, 1'b1);
            e0 = predict(m0_p, 1'b0);
            check("u1.stall_pc",     32'(spc1), 32'(e1.stall));
            check("u1.stall_ifid",   32'(sif1), 32'(e1.stall));
            check("u1.flush_ifid",   32'(fif1), 32'(e1.flush));
            check("u1.flush_idex",   32'(fex1), 32'(e1.flush));
            check("u1.fwd_a",        32'(fa1),  32'(e1.fa));
            check("u1.fwd_b",        32'(fb1),  32'(e1.fb));
            check("u1.stall_cycles", cnt1,      m1_cnt[31:0]);
            check("u0.stall_pc",     32'(spc0), 32'(e0.stall));
            check("u0.stall_ifid",   32'(sif0), 32'(e0.stall));
            check("u0.flush_ifid",   32'(fif0), 32'(e0.flush));
            check("u0.flush_idex",   32'(fex0), 32'(e0.flush));
            check("u0.fwd_a",        32'(fa0),  32'(e0.fa));
            check("u0.fwd_b",        32'(fb0),  32'(e0.fb));
            check("u0.stall_cycles", 32'(cnt0), 32'(m0_cnt));
        end
    end

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic re1, input logic re2, input logic we,
                         input logic [1:0] wsel, input logic redir);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_re1 = re1; id_re2 = re2;
        id_rf_we = we; id_wd_sel = wsel; ex_redirect = redir;
    endtask

    task automatic nop();
        instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // ALU producer followed by a consumer of x1
        do_reset();
        instr(5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        step();
        instr(5'd1, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        sample();
`ifdef FORWARD_EN
        check("T1.fwd_a", 32'(fa1), 32'd1);
        check("T1.fwd_b", 32'(fb1), 32'd1);
        check("T1.stall", 32'(spc1), 32'd0);
        step();
        nop();
`else
        check("T5.c0.stall1", 32'(spc1), 32'd1);
        check("T5.c0.stall0", 32'(spc0), 32'd1);
        check("T5.c0.fwd_a",  32'(fa1),  32'd0);
        step();
        sample();
        check("T5.c1.stall1", 32'(spc1), 32'd1);
        check("T5.c1.stall0", 32'(spc0), 32'd1);
        step();
        sample();
        check("T5.c2.stall1", 32'(spc1), 32'd0);
        check("T5.c2.stall0", 32'(spc0), 32'd1);
        step();
        sample();
        check("T5.c3.stall0", 32'(spc0), 32'd0);
        check("T5.cnt1",      cnt1,      32'd2);
        check("T5.cnt0",      32'(cnt0), 32'd3);
`endif

        // Load-use: lw x5 ; add x6,x5,x0
        do_reset();
        instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        step();
        instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        sample();
        check("T2.stall_pc",   32'(spc1), 32'd1);
        check("T2.stall_ifid", 32'(sif1), 32'd1);
        check("T2.cnt_before", cnt1,      32'd0);
        step();
        sample();
`ifdef FORWARD_EN
        check("T2.next.stall", 32'(spc1), 32'd0);
        check("T2.next.fwd_a", 32'(fa1),  32'd2);
        check("T2.next.fwd_b", 32'(fb1),  32'd0);
`else
        check("T2.next.stall", 32'(spc1), 32'd1);
`endif
        check("T2.next.cnt", cnt1, 32'd1);

        // Writes to x0 never hazard
        do_reset();
        instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        step();
        instr(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        sample();
        check("T3.fwd_a",  32'(fa1),  32'd0);
        check("T3.fwd_b",  32'(fb1),  32'd0);
        check("T3.stall1", 32'(spc1), 32'd0);
        check("T3.stall0", 32'(spc0), 32'd0);

        // Redirect coinciding with load-use
        do_reset();
        instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        step();
        instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        sample();
        check("T4.flush_ifid", 32'(fif1), 32'd1);
        check("T4.flush_idex", 32'(fex1), 32'd1);
        check("T4.stall_pc",   32'(spc1), 32'd0);
        step();
        // The discarded add x6 must not be seen as in flight
        instr(5'd6, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        sample();
        check("T4.bubble.stall1", 32'(spc1), 32'd0);
        check("T4.bubble.stall0", 32'(spc0), 32'd0);
        check("T4.bubble.fwd_a",  32'(fa1),  32'd0);

        // Reset asserted while a load-use stall is active
        do_reset();
        instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        step();
        instr(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        sample();
        check("T6.pre.stall", 32'(spc1), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("T6.rst.stall_pc",   32'(spc1), 32'd0);
        check("T6.rst.stall_ifid", 32'(sif1), 32'd0);
        check("T6.rst.fwd_a",      32'(fa1),  32'd0);
        step();
        sample();
        check("T6.rst.cnt", cnt1, 32'd0);
        step();
        rst = 1'b0;
        sample();
        check("T6.post.stall1", 32'(spc1), 32'd0);
        check("T6.post.stall0", 32'(spc0), 32'd0);
        check("T6.post.fwd_a",  32'(fa1),  32'd0);
        check("T6.post.cnt",    cnt1,      32'd0);

        // Randomised traffic over a small register window for dense hazards
        do_reset();
        repeat (3000) begin
            step();
            rst         = ($urandom_range(0, 149) == 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_re1      = 1'($urandom_range(0, 1));
            id_re2      = 1'($urandom_range(0, 1));
            id_rf_we    = ($urandom_range(0, 3) != 0);
            id_wd_sel   = 2'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 7) == 0);
        end
        step();
        nop();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
